// File: rtl/fp16_mul_pipe.sv
// Three-stage IEEE-754 binary16 multiplier (round-to-nearest-even, flush-to-zero).
// Stages are unpack/classify, then mantissa product and exponent sum, then normalize/round/pack.
module fp16_mul_pipe #(
    parameter logic [15:0] CANON_NAN = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    input  logic        stall,
    output logic [15:0] x,
    output logic        out_valid
);

    // Stage 1 registers: unpacked operands plus the special-case verdict
    logic        s1Valid_q, s1Valid_d;
    logic        s1SignA_q, s1SignA_d;
    logic        s1SignB_q, s1SignB_d;
    logic [4:0]  s1ExpA_q, s1ExpA_d;
    logic [4:0]  s1ExpB_q, s1ExpB_d;
    logic [10:0] s1ManA_q, s1ManA_d;
    logic [10:0] s1ManB_q, s1ManB_d;
    logic        s1Nan_q, s1Nan_d;
    logic        s1Inf_q, s1Inf_d;
    logic        s1Zero_q, s1Zero_d;

    // Stage 2 registers
    logic               s2Valid_q, s2Valid_d;
    logic               s2Sign_q, s2Sign_d;
    logic [21:0]        s2Prod_q, s2Prod_d;
    logic signed [6:0]  s2Exp_q, s2Exp_d;
    logic               s2Nan_q, s2Nan_d;
    logic               s2Inf_q, s2Inf_d;
    logic               s2Zero_q, s2Zero_d;

    // Stage 3 registers
    logic [15:0] x_q, x_d;
    logic        outValid_q, outValid_d;

    logic aNan, aInf, aZero, bNan, bInf, bZero;

    // Subnormal inputs have exponent 0 and are classified as zero
    always_comb begin
        aNan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
        aInf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
        aZero = (a[14:10] == 5'h00);
        bNan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
        bInf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
        bZero = (b[14:10] == 5'h00);

        s1Valid_d = in_valid;
        s1SignA_d = a[15];
        s1SignB_d = b[15];
        s1ExpA_d  = a[14:10];
        s1ExpB_d  = b[14:10];
        s1ManA_d  = {1'b1, a[9:0]};
        s1ManB_d  = {1'b1, b[9:0]};
        s1Nan_d   = aNan || bNan || (aInf && bZero) || (bInf && aZero);
        s1Inf_d   = !s1Nan_d && (aInf || bInf);
        s1Zero_d  = !s1Nan_d && !s1Inf_d && (aZero || bZero);
    end

    always_comb begin
        s2Valid_d = s1Valid_q;
        s2Sign_d  = s1SignA_q ^ s1SignB_q;
        s2Prod_d  = {11'b0, s1ManA_q} * {11'b0, s1ManB_q};
        s2Exp_d   = $signed({2'b00, s1ExpA_q}) + $signed({2'b00, s1ExpB_q}) - 7'sd15;
        s2Nan_d   = s1Nan_q;
        s2Inf_d   = s1Inf_q;
        s2Zero_d  = s1Zero_q;
    end

    logic [9:0]        fracNorm;
    logic              guardBit, stickyBit, roundInc, fracCarry;
    logic [9:0]        fracRound;
    logic signed [6:0] expNorm, expFinal;
    logic [15:0]       packed16;

    // Normalize on product bit 21, round to nearest even, then resolve range and specials
    always_comb begin
        if (s2Prod_q[21]) begin
            fracNorm  = s2Prod_q[20:11];
            guardBit  = s2Prod_q[10];
            stickyBit = |s2Prod_q[9:0];
            expNorm   = s2Exp_q + 7'sd1;
        end else begin
            fracNorm  = s2Prod_q[19:10];
            guardBit  = s2Prod_q[9];
            stickyBit = |s2Prod_q[8:0];
            expNorm   = s2Exp_q;
        end
        roundInc                = guardBit && (stickyBit || fracNorm[0]);
        {fracCarry, fracRound}  = {1'b0, fracNorm} + {10'b0, roundInc};
        expFinal                = expNorm + $signed({6'b0, fracCarry});

        if (s2Nan_q) begin
            packed16 = CANON_NAN;
        end else if (s2Inf_q) begin
            packed16 = {s2Sign_q, 5'h1F, 10'h000};
        end else if (s2Zero_q || (expFinal <= 7'sd0)) begin
            packed16 = {s2Sign_q, 15'h0000};
        end else if (expFinal >= 7'sd31) begin
            packed16 = {s2Sign_q, 5'h1F, 10'h000};
        end else begin
            packed16 = {s2Sign_q, expFinal[4:0], fracRound};
        end

        outValid_d = s2Valid_q;
        x_d        = s2Valid_q ? packed16 : x_q;
    end

    // Every register advances together unless the global stall holds them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1SignA_q  <= 1'b0;
            s1SignB_q  <= 1'b0;
            s1ExpA_q   <= 5'h00;
            s1ExpB_q   <= 5'h00;
            s1ManA_q   <= 11'h000;
            s1ManB_q   <= 11'h000;
            s1Nan_q    <= 1'b0;
            s1Inf_q    <= 1'b0;
            s1Zero_q   <= 1'b0;
            s2Valid_q  <= 1'b0;
            s2Sign_q   <= 1'b0;
            s2Prod_q   <= 22'h000000;
            s2Exp_q    <= 7'sd0;
            s2Nan_q    <= 1'b0;
            s2Inf_q    <= 1'b0;
            s2Zero_q   <= 1'b0;
            x_q        <= 16'h0000;
            outValid_q <= 1'b0;
        end else if (!stall) begin
            s1Valid_q  <= s1Valid_d;
            s1SignA_q  <= s1SignA_d;
            s1SignB_q  <= s1SignB_d;
            s1ExpA_q   <= s1ExpA_d;
            s1ExpB_q   <= s1ExpB_d;
            s1ManA_q   <= s1ManA_d;
            s1ManB_q   <= s1ManB_d;
            s1Nan_q    <= s1Nan_d;
            s1Inf_q    <= s1Inf_d;
            s1Zero_q   <= s1Zero_d;
            s2Valid_q  <= s2Valid_d;
            s2Sign_q   <= s2Sign_d;
            s2Prod_q   <= s2Prod_d;
            s2Exp_q    <= s2Exp_d;
            s2Nan_q    <= s2Nan_d;
            s2Inf_q    <= s2Inf_d;
            s2Zero_q   <= s2Zero_d;
            x_q        <= x_d;
            outValid_q <= outValid_d;
        end
    end

    assign x         = x_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_fp16_mul_pipe.sv
// Self-checking bench for fp16_mul_pipe: directed cases plus randomized traffic
// compared against a real-arithmetic binary16 reference and a delay-line timing model.
module tb_fp16_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        in_valid, stall;
    logic [15:0] x;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    fp16_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .stall     (stall),
        .x         (x),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Value of a normal binary16 magnitude
    function automatic real fpMag(input logic [15:0] v);
        int e = int'(v[14:10]);
        int f = int'(v[9:0]);
        return (1.0 + real'(f) / 1024.0) * pow2(e - 15);
    endfunction

    // Round a positive real to binary16 with nearest-even and flush-to-zero
    function automatic logic [15:0] fromReal(input logic s, input real m);
        int   e = 0;
        real  sig, fr;
        int   ip, be, fracInt;
        logic [15:0] r;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        sig = m * 1024.0;
        ip  = $rtoi(sig);
        fr  = sig - real'(ip);
        if (fr > 0.5 || (fr == 0.5 && (ip % 2 == 1))) ip++;
        if (ip >= 2048) begin ip = 1024; e++; end
        be = e + 15;
        if (be <= 0) return {s, 15'h0000};
        if (be >= 31) return {s, 5'h1F, 10'h000};
        fracInt = ip - 1024;
        r = {s, be[4:0], fracInt[9:0]};
        return r;
    endfunction

    function automatic logic [15:0] refMul(input logic [15:0] p, input logic [15:0] q);
        logic s     = p[15] ^ q[15];
        logic pNan  = (p[14:10] == 5'h1F) && (p[9:0] != 0);
        logic qNan  = (q[14:10] == 5'h1F) && (q[9:0] != 0);
        logic pInf  = (p[14:10] == 5'h1F) && (p[9:0] == 0);
        logic qInf  = (q[14:10] == 5'h1F) && (q[9:0] == 0);
        logic pZero = (p[14:10] == 5'h00);
        logic qZero = (q[14:10] == 5'h00);
        if (pNan || qNan || (pInf && qZero) || (qInf && pZero)) return 16'h7E00;
        if (pInf || qInf) return {s, 5'h1F, 10'h000};
        if (pZero || qZero) return {s, 15'h0000};
        return fromReal(s, fpMag(p) * fpMag(q));
    endfunction

    task automatic test_reset();
        rst = 1'b1; a = 16'h3C00; b = 16'h3C00; in_valid = 1'b1; stall = 1'b0;
        tick();
        tick();
        checks++;
        if (x !== 16'h0000 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: x=%h out_valid=%b required x=0000 out_valid=0", x, out_valid);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        a = 16'h3E00; b = 16'h4000; in_valid = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            in_valid = 1'b0;
            checks++;
            if (e < 2 && out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL latency_early edge%0d: out_valid=%b required 0", e, out_valid);
            end else if (e == 2 && (out_valid !== 1'b1 || x !== 16'h4200)) begin
                errors++;
                $display("[TB] FAIL latency_result: x=%h out_valid=%b required x=4200 out_valid=1", x, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] opA [4] = '{16'h3E00, 16'hC000, 16'h3C01, 16'h3C01};
        logic [15:0] opB [4] = '{16'h3E00, 16'h4200, 16'h3C01, 16'h3E00};
        logic [15:0] expX[4] = '{16'h4080, 16'hC600, 16'h3C02, 16'h3E02};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                a = opA[i]; b = opB[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || x !== expX[i-2]) begin
                    errors++;
                    $display("[TB] FAIL back_to_back[%0d]: x=%h out_valid=%b required x=%h out_valid=1",
                             i - 2, x, out_valid, expX[i-2]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_specials();
        logic [15:0] opA [6] = '{16'h7BFF, 16'h0400, 16'h8000, 16'h7C00, 16'h7E00, 16'h0200};
        logic [15:0] opB [6] = '{16'h4000, 16'h3800, 16'h4200, 16'h0000, 16'h3C00, 16'h4000};
        logic [15:0] expX[6] = '{16'h7C00, 16'h0000, 16'h8000, 16'h7E00, 16'h7E00, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            a = opA[i]; b = opB[i]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            checks++;
            if (out_valid !== 1'b1 || x !== expX[i]) begin
                errors++;
                $display("[TB] FAIL special %h*%h: x=%h out_valid=%b required x=%h out_valid=1",
                         opA[i], opB[i], x, out_valid, expX[i]);
            end
        end
        tick();
    endtask

    task automatic test_stall();
        logic [15:0] heldX;
        a = 16'h3E00; b = 16'h4000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        heldX = x;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || x !== heldX) begin
                errors++;
                $display("[TB] FAIL stall_frozen[%0d]: x=%h out_valid=%b required x=%h out_valid=0",
                         i, x, out_valid, heldX);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || x !== 16'h4200) begin
            errors++;
            $display("[TB] FAIL stall_result: x=%h out_valid=%b required x=4200 out_valid=1", x, out_valid);
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || x !== 16'h4200) begin
                errors++;
                $display("[TB] FAIL stall_hold_valid[%0d]: x=%h out_valid=%b required x=4200 out_valid=1",
                         i, x, out_valid);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release_bubble: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] opA [3] = '{16'h3E00, 16'h4000, 16'h4200};
        for (int i = 0; i < 3; i++) begin
            a = opA[i]; b = 16'h4000; in_valid = 1'b1;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (x !== 16'h0000 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: x=%h out_valid=%b required x=0000 out_valid=0", x, out_valid);
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_no_spurious[%0d]: out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    function automatic logic [15:0] randOperand();
        logic [15:0] v = 16'($urandom);
        case ($urandom_range(0, 9))
            0: v[14:10] = 5'h00;
            1: v[14:10] = 5'h1F;
            2: v[9:0]   = 10'h000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic        pipeV [3] = '{1'b0, 1'b0, 1'b0};
        logic [15:0] pipeX [3] = '{16'h0, 16'h0, 16'h0};
        logic [15:0] expX = 16'h0000;
        logic [15:0] refVal;
        for (int cyc = 0; cyc < 600; cyc++) begin
            a        = randOperand();
            b        = randOperand();
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            refVal   = refMul(a, b);
            @(posedge clk);
            if (!stall) begin
                pipeV[2] = pipeV[1]; pipeX[2] = pipeX[1];
                pipeV[1] = pipeV[0]; pipeX[1] = pipeX[0];
                pipeV[0] = in_valid; pipeX[0] = refVal;
                if (pipeV[2]) expX = pipeX[2];
            end
            #1;
            checks++;
            if (out_valid !== pipeV[2] || x !== expX) begin
                errors++;
                $display("[TB] FAIL random cyc%0d: x=%h out_valid=%b required x=%h out_valid=%b",
                         cyc, x, out_valid, expX, pipeV[2]);
            end
        end
        stall = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_specials();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
